// File: rtl/bram_delay_prog.sv
// Run-time programmable BRAM delay line. Every ce-qualified {din_vld, din}
// is written into a circular RAM and read back delay_cur ce-cycles later.
// A fill counter holds busy high (and masks dout_vld) until the line holds
// data written under the current delay.
module bram_delay_prog #(
    parameter int WIDTH     = 32,
    parameter int MAX_DELAY = 1024,
    parameter int LATENCY   = 2,
    localparam int ADDR_BITS = $clog2(MAX_DELAY)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic [ADDR_BITS:0]   delay_in,
    input  logic                 delay_ld,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_vld,
    output logic [WIDTH-1:0]     dout,
    output logic                 dout_vld,
    output logic                 busy,
    output logic [ADDR_BITS:0]   delay_cur
);
    localparam int DW = ADDR_BITS + 1;
    localparam logic [DW-1:0] D_MIN = DW'(LATENCY + 1);
    localparam logic [DW-1:0] D_MAX = DW'(MAX_DELAY);
    localparam logic [DW-1:0] D_LAT = DW'(LATENCY);

    logic [WIDTH:0]          mem [MAX_DELAY];
    logic [ADDR_BITS-1:0]    wr_ptr;
    logic [ADDR_BITS-1:0]    rd_addr;
    logic [DW-1:0]           fill_cnt;
    logic [DW-1:0]           delay_clamped;
    logic [WIDTH-1:0]        rd_q;
    logic                    rd_vld;
    logic [WIDTH-1:0]        out_q;
    logic                    out_vld;

    // Clamp the requested delay into the range the read pipeline can honour
    always_comb begin
        delay_clamped = delay_in;
        if (delay_in < D_MIN)
            delay_clamped = D_MIN;
        else if (delay_in > D_MAX)
            delay_clamped = D_MAX;
    end

    // Read trails the write by (delay - LATENCY) so the pipeline makes up the rest;
    // the minimum clamp keeps this offset >= 1, so read never hits the write slot
    assign rd_addr = wr_ptr - ADDR_BITS'(delay_cur - D_LAT);

    // Circular RAM write port (contents deliberately not reset)
    always_ff @(posedge clk) begin
        if (ce)
            mem[wr_ptr] <= {din_vld, din};
    end

    // Write pointer advances one slot per ce cycle, wrapping naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wr_ptr <= '0;
        else if (ce)
            wr_ptr <= wr_ptr + 1'b1;
    end

    // Delay register and fill tracking; a load restarts the fill even if unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            delay_cur <= D_MAX;
            fill_cnt  <= '0;
            busy      <= 1'b1;
        end else if (ce) begin
            if (delay_ld) begin
                delay_cur <= delay_clamped;
                fill_cnt  <= '0;
                busy      <= 1'b1;
            end else if (busy) begin
                fill_cnt <= fill_cnt + 1'b1;
                if (fill_cnt == delay_cur - 1'b1)
                    busy <= 1'b0;
            end
        end
    end

    // Registered RAM read; valid bits are flushed on a delay load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q   <= '0;
            rd_vld <= 1'b0;
        end else if (ce) begin
            rd_q   <= mem[rd_addr][WIDTH-1:0];
            rd_vld <= mem[rd_addr][WIDTH] & ~delay_ld;
        end
    end

    generate
        if (LATENCY == 2) begin : g_oreg
            // Extra output register stage
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_q   <= '0;
                    out_vld <= 1'b0;
                end else if (ce) begin
                    out_q   <= rd_q;
                    out_vld <= rd_vld & ~delay_ld;
                end
            end
        end else begin : g_noreg
            assign out_q   = rd_q;
            assign out_vld = rd_vld;
        end
    endgenerate

    assign dout     = out_q;
    assign dout_vld = out_vld & ~busy;

endmodule

// File: tb/tb_bram_delay_prog.sv
// Directed bench for bram_delay_prog (default parameters). din is a ramp
// equal to the count of ce-high cycles, so at any point the expected dout
// is simply (cnt - delay).
module tb_bram_delay_prog;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce;
    logic [10:0]   delay_in;
    logic          delay_ld;
    logic [W-1:0]  din;
    logic          din_vld;
    logic [W-1:0]  dout;
    logic          dout_vld;
    logic          busy;
    logic [10:0]   delay_cur;

    int n_cmp = 0;
    int n_err = 0;
    int cnt   = 0;
    logic vld_next = 1'b1;
    bit hist_vld [0:8191];

    bram_delay_prog #(.WIDTH(W), .MAX_DELAY(1024), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .ce(ce), .delay_in(delay_in), .delay_ld(delay_ld),
        .din(din), .din_vld(din_vld), .dout(dout), .dout_vld(dout_vld),
        .busy(busy), .delay_cur(delay_cur)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, got, got, exp, exp);
        end
    endtask

    // One clock; ce=0 cycles present junk data that must not be stored
    task automatic tick(input logic c);
        ce      = c;
        din     = c ? W'(cnt) : 32'hDEAD_BEEF;
        din_vld = c ? vld_next : 1'b0;
        if (c) hist_vld[cnt] = vld_next;
        @(posedge clk);
        #1;
        if (c) cnt++;
    endtask

    // Load a delay, confirm the quiet fill window, then the first aligned output
    task automatic load_fill(input string tag, input logic [10:0] req, input int exp_d);
        int bad;
        delay_ld = 1'b1;
        delay_in = req;
        tick(1'b1);
        delay_ld = 1'b0;
        chk({tag, "_delay_cur"}, 32'(delay_cur), 32'(exp_d));
        bad = 0;
        for (int i = 0; i < exp_d - 1; i++) begin
            if (dout_vld !== 1'b0 || busy !== 1'b1) bad++;
            tick(1'b1);
        end
        if (dout_vld !== 1'b0 || busy !== 1'b1) bad++;
        chk({tag, "_fill_quiet"}, 32'(bad), 32'd0);
        tick(1'b1);
        chk({tag, "_busy_drop"}, 32'(busy), 32'd0);
        chk({tag, "_vld_up"}, 32'(dout_vld), 32'd1);
        chk({tag, "_first"}, dout, W'(cnt - exp_d));
    endtask

    // Run n ce-high cycles checking ramp alignment; one comparison per run
    task automatic run_check(input string tag, input int n, input int d);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            tick(1'b1);
            if (dout !== W'(cnt - d) || dout_vld !== 1'b1) bad++;
        end
        chk({tag, "_align"}, 32'(bad), 32'd0);
    endtask

    initial begin
        int bad;
        logic [W-1:0] fz_d;
        logic fz_v, fz_b;
        rst = 1'b1; ce = 1'b0; delay_in = '0; delay_ld = 1'b0;
        din = '0; din_vld = 1'b0;
        #12;
        // Reset state
        chk("rst_dout", dout, 32'd0);
        chk("rst_vld", 32'(dout_vld), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_delay", 32'(delay_cur), 32'd1024);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // 1: default delay fill, first sample 0, then ramp
        bad = 0;
        for (int i = 0; i < 1023; i++) begin
            tick(1'b1);
            if (busy !== 1'b1 || dout_vld !== 1'b0) bad++;
        end
        chk("t1_fill_quiet", 32'(bad), 32'd0);
        tick(1'b1);
        chk("t1_busy_drop", 32'(busy), 32'd0);
        chk("t1_vld_up", 32'(dout_vld), 32'd1);
        chk("t1_first", dout, 32'd0);
        run_check("t1", 10, 1024);

        // 2: delay 5
        load_fill("t2", 11'd5, 5);
        run_check("t2", 10, 5);

        // 3: clamp extremes (4000 truncates to 1952 in 11 bits, still above max)
        load_fill("t3lo", 11'd0, 3);
        run_check("t3lo", 8, 3);
        load_fill("t3hi", 11'(4000), 1024);
        run_check("t3hi", 8, 1024);

        // 4: ce toggling with delay 8; outputs frozen on ce=0
        load_fill("t4", 11'd8, 8);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            fz_d = dout; fz_v = dout_vld; fz_b = busy;
            tick(1'b0);
            if (dout !== fz_d || dout_vld !== fz_v || busy !== fz_b || delay_cur !== 11'd8) bad++;
            tick(1'b1);
            if (dout !== W'(cnt - 8) || dout_vld !== 1'b1) bad++;
        end
        chk("t4_ce_toggle", 32'(bad), 32'd0);

        // 5: valid pattern 1,0,0,1 reproduced 16 cycles later
        load_fill("t5", 11'd16, 16);
        bad = 0;
        for (int i = 0; i < 24; i++) begin
            vld_next = (i == 1 || i == 2) ? 1'b0 : 1'b1;
            tick(1'b1);
            if (dout_vld !== hist_vld[cnt - 16]) bad++;
        end
        vld_next = 1'b1;
        chk("t5_vld_pattern", 32'(bad), 32'd0);
        chk("t5_vld_zero_seen", 32'(hist_vld[cnt - 24 + 1]), 32'd0);

        // 6: async reset between edges
        tick(1'b1);
        #2 rst = 1'b1;
        #1;
        chk("t6_dout", dout, 32'd0);
        chk("t6_vld", 32'(dout_vld), 32'd0);
        chk("t6_busy", 32'(busy), 32'd1);
        chk("t6_delay", 32'(delay_cur), 32'd1024);
        @(negedge clk); rst = 1'b0;
        #1;
        bad = 0;
        for (int i = 0; i < 1023; i++) begin
            tick(1'b1);
            if (busy !== 1'b1) bad++;
        end
        chk("t6_fill_quiet", 32'(bad), 32'd0);
        tick(1'b1);
        chk("t6_busy_drop", 32'(busy), 32'd0);
        run_check("t6", 6, 1024);

        // 7: two loads 3 cycles apart; the second one wins
        delay_ld = 1'b1; delay_in = 11'd10;
        tick(1'b1);
        delay_ld = 1'b0;
        tick(1'b1);
        tick(1'b1);
        load_fill("t7", 11'd20, 20);
        run_check("t7", 6, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute bound so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
